// File: rtl/frame_byte_feeder.sv
// frame_byte_feeder: byte-wide front end of the 8:1 DDR output serializer.
// Buffers payload bytes in a small FIFO and sends one byte per divided-clock
// cycle: training bursts, idle fill, and frames wrapped as SOF/payload/EOF.
module frame_byte_feeder #(
  parameter int          DEPTH       = 16,
  parameter int          TRAIN_WORDS = 64,
  parameter int          MIN_GAP     = 2,
  parameter logic [7:0]  TRAIN_BYTE  = 8'hAA,
  parameter logic [7:0]  IDLE_BYTE   = 8'hBC,
  parameter logic [7:0]  SOF_BYTE    = 8'hFB,
  parameter logic [7:0]  EOF_BYTE    = 8'hFD,
  parameter logic [7:0]  FILL_BYTE   = 8'h1C
) (
  input  logic        clk_div,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  input  logic        retrain,
  output logic [7:0]  dout,
  output logic        oce,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frame_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (TRAIN_WORDS > MIN_GAP) ? TRAIN_WORDS : MIN_GAP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] FULL       = CW'(DEPTH);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_WORDS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(MIN_GAP - 1);

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_EOF,
    ST_GAP
  } state_t;

  // FIFO storage: each entry is {last, data}
  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] frames_pending;
  logic          push;
  logic          pop;
  logic [8:0]    head;

  // Sequencer state
  state_t        state;
  logic [TW-1:0] tmr;
  logic          retrain_pend;

  // s_ready is a registered copy of (count < DEPTH), so a full FIFO refuses
  // a byte even in a cycle where the sequencer pops one.
  assign push       = s_valid && s_ready;
  assign head       = mem[rd_ptr];
  assign pop        = (state == ST_PAYLOAD) && (count != '0);
  assign count_next = count + CW'(push) - CW'(pop);

  // FIFO entry write
  // NOTE: the storage array has no reset; emptying the FIFO only needs the
  // pointers and count cleared, and a resettable array costs far more logic.
  always_ff @(posedge clk_div) begin
    if (push) begin
      mem[wr_ptr] <= {s_last, s_data};
    end
  end

  // FIFO pointers, occupancy, pending-frame count and ready flag
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_div) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      frames_pending <= '0;
      s_ready        <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count          <= count_next;
      frames_pending <= frames_pending + CW'(push && s_last) - CW'(pop && head[8]);
      s_ready        <= (count_next < FULL);
    end
  end

  // Frame sequencer: registers the byte for this cycle and picks the next state
  always_ff @(posedge clk_div) begin
    if (!rst) begin
      state        <= ST_TRAIN;
      tmr          <= '0;
      retrain_pend <= 1'b0;
      dout         <= 8'h00;
      oce          <= 1'b0;
      busy         <= 1'b0;
      underrun     <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      oce      <= 1'b1;
      underrun <= 1'b0;

      // A request seen in any cycle wins over the clear on entry to TRAIN, so
      // a request during a burst queues another burst after it.
      if (retrain) begin
        retrain_pend <= 1'b1;
      end else if (state == ST_IDLE && retrain_pend) begin
        retrain_pend <= 1'b0;
      end

      case (state)
        ST_TRAIN: begin
          dout <= TRAIN_BYTE;
          busy <= 1'b1;
          if (tmr == TRAIN_LAST) begin
            tmr   <= '0;
            state <= ST_GAP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_GAP: begin
          dout <= IDLE_BYTE;
          if (tmr == GAP_LAST) begin
            tmr   <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tmr  <= tmr + 1'b1;
            busy <= 1'b1;
          end
        end
        ST_IDLE: begin
          dout <= IDLE_BYTE;
          if (retrain_pend) begin
            state <= ST_TRAIN;
            busy  <= 1'b1;
          end else if (frames_pending != '0 || count == FULL) begin
            // A full FIFO starts a frame even without its last byte, since
            // nothing more can be accepted until bytes drain.
            state <= ST_SOF;
            busy  <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        ST_SOF: begin
          dout  <= SOF_BYTE;
          state <= ST_PAYLOAD;
          busy  <= 1'b1;
        end
        ST_PAYLOAD: begin
          busy <= 1'b1;
          if (count == '0) begin
            dout     <= FILL_BYTE;
            underrun <= 1'b1;
          end else begin
            dout <= head[7:0];
            if (head[8]) begin
              state <= ST_EOF;
            end
          end
        end
        ST_EOF: begin
          dout      <= EOF_BYTE;
          frame_cnt <= frame_cnt + 16'd1;
          state     <= ST_GAP;
          busy      <= 1'b1;
        end
        default: begin
          dout  <= IDLE_BYTE;
          tmr   <= '0;
          state <= ST_TRAIN;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_byte_feeder.sv
// tb_frame_byte_feeder: directed scenarios plus a randomized run, all checked
// against a schedule-based reference model (FIFO as a queue, output plan as a
// queue of upcoming bytes).
module tb_frame_byte_feeder;

  localparam int         DEPTH       = 16;
  localparam int         TRAIN_WORDS = 64;
  localparam int         MIN_GAP     = 2;
  localparam logic [7:0] B_TRAIN     = 8'hAA;
  localparam logic [7:0] B_IDLE      = 8'hBC;
  localparam logic [7:0] B_SOF       = 8'hFB;
  localparam logic [7:0] B_EOF       = 8'hFD;
  localparam logic [7:0] B_FILL      = 8'h1C;
  localparam int         EOF_MARK    = 32'h1FD;

  logic        clk_div = 1'b0;
  logic        rst     = 1'b0;
  logic [7:0]  s_data  = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        retrain = 1'b0;
  logic        s_ready;
  logic [7:0]  dout;
  logic        oce;
  logic        busy;
  logic        underrun;
  logic [15:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  frame_byte_feeder dut (
    .clk_div   (clk_div),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .retrain   (retrain),
    .dout      (dout),
    .oce       (oce),
    .busy      (busy),
    .underrun  (underrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk_div = ~clk_div;

  // ---------------- reference model ----------------
  logic [8:0]  fifo_q [$];   // buffered {last, data}
  int          plan_q [$];   // fixed bytes still to be sent (EOF_MARK counts a frame)
  bit          in_payload;
  bit          retrain_flag;
  logic [15:0] m_cnt;
  logic [7:0]  exp_dout;
  logic        exp_under;
  logic        exp_busy;
  logic        exp_oce;
  logic        exp_ready;
  logic        model_diff;

  assign model_diff = (dout !== exp_dout) || (underrun !== exp_under) || (busy !== exp_busy) ||
                      (oce !== exp_oce) || (s_ready !== exp_ready) || (frame_cnt !== m_cnt);

  function automatic int frames_queued();
    int n = 0;
    foreach (fifo_q[i]) if (fifo_q[i][8]) n++;
    return n;
  endfunction

  function automatic string obs();
    return $sformatf("got dout=%h und=%b busy=%b oce=%b rdy=%b cnt=%h want dout=%h und=%b busy=%b oce=%b rdy=%b cnt=%h",
                     dout, underrun, busy, oce, s_ready, frame_cnt,
                     exp_dout, exp_under, exp_busy, exp_oce, exp_ready, m_cnt);
  endfunction

  task automatic model_reset();
    fifo_q.delete();
    plan_q.delete();
    repeat (TRAIN_WORDS) plan_q.push_back(int'(B_TRAIN));
    repeat (MIN_GAP) plan_q.push_back(int'(B_IDLE));
    in_payload   = 1'b0;
    retrain_flag = 1'b0;
    m_cnt        = 16'h0000;
    exp_dout     = 8'h00;
    exp_under    = 1'b0;
    exp_busy     = 1'b0;
    exp_oce      = 1'b0;
    exp_ready    = 1'b0;
  endtask

  // Advance one clock edge, update the model with the inputs present at the
  // edge, then wait 1 time unit so outputs are sampled away from the edge.
  task automatic step();
    int         p;
    logic [8:0] e;
    bit         push;
    @(posedge clk_div);
    if (!rst) begin
      model_reset();
    end else begin
      push      = s_valid && exp_ready;
      exp_under = 1'b0;
      if (plan_q.size() > 0) begin
        p        = plan_q.pop_front();
        exp_dout = p[7:0];
        if (p == EOF_MARK) m_cnt = m_cnt + 16'd1;
      end else if (in_payload) begin
        if (fifo_q.size() == 0) begin
          exp_dout  = B_FILL;
          exp_under = 1'b1;
        end else begin
          e        = fifo_q.pop_front();
          exp_dout = e[7:0];
          if (e[8]) begin
            in_payload = 1'b0;
            plan_q.push_back(EOF_MARK);
            repeat (MIN_GAP) plan_q.push_back(int'(B_IDLE));
          end
        end
      end else begin
        exp_dout = B_IDLE;
        if (retrain_flag) begin
          retrain_flag = 1'b0;
          repeat (TRAIN_WORDS) plan_q.push_back(int'(B_TRAIN));
          repeat (MIN_GAP) plan_q.push_back(int'(B_IDLE));
        end else if (frames_queued() > 0 || fifo_q.size() == DEPTH) begin
          plan_q.push_back(int'(B_SOF));
          in_payload = 1'b1;
        end
      end
      if (retrain) retrain_flag = 1'b1;
      if (push) fifo_q.push_back({s_last, s_data});
      exp_ready = (fifo_q.size() < DEPTH);
      exp_busy  = (plan_q.size() > 0) || in_payload;
      exp_oce   = 1'b1;
    end
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_quiet(input int n);
    s_valid = 1'b0; s_last = 1'b0; retrain = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL quiet_model i=%0d %s", i, obs()); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; s_valid = 1'b0; s_last = 1'b0; retrain = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dout !== 8'h00 || oce !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0 ||
          underrun !== 1'b0 || frame_cnt !== 16'h0000) begin
        failures++;
        $display("FAIL reset_outputs i=%0d got dout=%h oce=%b busy=%b rdy=%b und=%b cnt=%h want all zero",
                 i, dout, oce, busy, s_ready, underrun, frame_cnt);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < TRAIN_WORDS; i++) begin
      step();
      checks++;
      if (dout !== B_TRAIN || oce !== 1'b1) begin
        failures++; $display("FAIL train_burst i=%0d got dout=%h oce=%b want dout=%h oce=1", i, dout, oce, B_TRAIN);
      end
      checks++;
      if (model_diff) begin failures++; $display("FAIL train_model i=%0d %s", i, obs()); end
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (dout !== B_IDLE || (i >= MIN_GAP && busy !== 1'b0)) begin
        failures++; $display("FAIL idle_after_train i=%0d got dout=%h busy=%b want dout=%h busy=0", i, dout, busy, B_IDLE);
      end
      checks++;
      if (model_diff) begin failures++; $display("FAIL idle_model i=%0d %s", i, obs()); end
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] want [8];
    logic [7:0] vals [3];
    want = '{8'hBC, 8'hFB, 8'h11, 8'h22, 8'h33, 8'hFD, 8'hBC, 8'hBC};
    vals = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 11; i++) begin
      s_valid = (i < 3);
      s_data  = vals[i % 3];
      s_last  = (i == 2);
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL single_model i=%0d %s", i, obs()); end
      if (i >= 3) begin
        checks++;
        if (dout !== want[i-3]) begin
          failures++; $display("FAIL single_frame_seq k=%0d got %h want %h", i - 3, dout, want[i-3]);
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL single_frame_cnt got %h want 0001", frame_cnt); end
  endtask

  task automatic test_two_frames();
    logic [7:0] want [10];
    logic [7:0] vals [3];
    want = '{8'hFB, 8'h01, 8'hFD, 8'hBC, 8'hBC, 8'hBC, 8'hFB, 8'h02, 8'h03, 8'hFD};
    vals = '{8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 12; i++) begin
      s_valid = (i < 3);
      s_data  = vals[i % 3];
      s_last  = (i == 0) || (i == 2);
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL two_frames_model i=%0d %s", i, obs()); end
      if (i >= 2) begin
        checks++;
        if (dout !== want[i-2]) begin
          failures++; $display("FAIL back_to_back_seq k=%0d got %h want %h", i - 2, dout, want[i-2]);
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (frame_cnt !== 16'd3) begin failures++; $display("FAIL two_frames_cnt got %h want 0003", frame_cnt); end
  endtask

  task automatic test_retrain_midframe();
    logic [7:0] want [74];
    for (int k = 0; k < 74; k++) begin
      if (k < 4)                        want[k] = 8'hA1 + 8'(k);
      else if (k == 4)                  want[k] = B_EOF;
      else if (k < 8)                   want[k] = B_IDLE;
      else if (k < 8 + TRAIN_WORDS)     want[k] = B_TRAIN;
      else                              want[k] = B_IDLE;
    end
    for (int i = 0; i < 80; i++) begin
      s_valid = (i < 4);
      s_data  = 8'hA1 + 8'(i);
      s_last  = (i == 3);
      retrain = (i == 7);
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL retrain_model i=%0d %s", i, obs()); end
      if (i >= 6) begin
        checks++;
        if (dout !== want[i-6]) begin
          failures++; $display("FAIL retrain_midframe_seq k=%0d got %h want %h", i - 6, dout, want[i-6]);
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0; retrain = 1'b0;
    checks++;
    if (frame_cnt !== 16'd4) begin failures++; $display("FAIL retrain_frame_cnt got %h want 0004", frame_cnt); end
  endtask

  task automatic test_backpressure();
    logic [7:0] dv [20];
    int   accepted = 0;
    int   idx      = 0;
    bit   found    = 1'b0;
    logic rdy_before;
    for (int i = 0; i < 20; i++) dv[i] = 8'h40 + 8'(i);
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    checks++;
    if (model_diff) begin failures++; $display("FAIL bp_retrain_model %s", obs()); end
    for (int c = 0; c < 20; c++) begin
      s_valid    = 1'b1;
      s_last     = 1'b0;
      s_data     = dv[idx];
      rdy_before = s_ready;
      step();
      if (rdy_before === 1'b1) begin accepted++; idx++; end
      checks++;
      if (model_diff) begin failures++; $display("FAIL bp_push_model c=%0d %s", c, obs()); end
    end
    s_valid = 1'b0;
    checks++;
    if (accepted != DEPTH || s_ready !== 1'b0) begin
      failures++; $display("FAIL bp_accept_count got %0d rdy=%b want %0d rdy=0", accepted, s_ready, DEPTH);
    end
    for (int w = 0; w < 150 && !found; w++) begin
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL bp_wait_model w=%0d %s", w, obs()); end
      if (dout === B_SOF) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL bp_sof_timeout got no %h within 150 cycles want %h", B_SOF, B_SOF); end
    for (int k = 0; k < DEPTH; k++) begin
      step();
      checks++;
      if (dout !== dv[k] || underrun !== 1'b0) begin
        failures++; $display("FAIL bp_payload k=%0d got %h und=%b want %h und=0", k, dout, underrun, dv[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (dout !== B_FILL || underrun !== 1'b1) begin
        failures++; $display("FAIL bp_fill k=%0d got %h und=%b want %h und=1", k, dout, underrun, B_FILL);
      end
    end
    s_valid = 1'b1; s_data = 8'h77; s_last = 1'b1;
    step();
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (model_diff) begin failures++; $display("FAIL bp_late_push_model %s", obs()); end
    step();
    checks++;
    if (dout !== 8'h77 || underrun !== 1'b0) begin
      failures++; $display("FAIL bp_late_byte got %h und=%b want 77 und=0", dout, underrun);
    end
    step();
    checks++;
    if (dout !== B_EOF || frame_cnt !== 16'd5) begin
      failures++; $display("FAIL bp_eof got %h cnt=%h want %h cnt=0005", dout, frame_cnt, B_EOF);
    end
  endtask

  task automatic test_wrap();
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    m_cnt = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      s_valid = (i == 0);
      s_data  = 8'h5A;
      s_last  = (i == 0);
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL wrap_model i=%0d %s", i, obs()); end
    end
    s_valid = 1'b0; s_last = 1'b0;
    checks++;
    if (frame_cnt !== 16'h0000) begin failures++; $display("FAIL frame_cnt_wrap got %h want 0000", frame_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) begin
      rst     = !(i >= 1200 && i < 1203);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 4) == 0);
      retrain = ($urandom_range(0, 199) == 0);
      step();
      checks++;
      if (model_diff) begin failures++; $display("FAIL random_model i=%0d %s", i, obs()); end
    end
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; retrain = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk_div);
    test_reset();
    test_quiet(4);
    test_single_frame();
    test_quiet(6);
    test_two_frames();
    test_quiet(6);
    test_retrain_midframe();
    test_quiet(6);
    test_backpressure();
    test_quiet(8);
    test_wrap();
    test_quiet(4);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
